axi_reg_slice: RTL

Parametrised AXI-channel register slice for any single valid/ready channel (AW/W/AR/R/B). MODE selects bypass, forward-registered, backward-registered (skid), or fully registered. It breaks timing paths on valid/data, on ready, or on both between a master-side and a slave-side interface. It preserves ordering, never drops or duplicates a beat, and sustains one beat per cycle in every mode.

---
 rtl/axi_reg_slice.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/axi_reg_slice.sv
// axi_reg_slice
//   Register slice for a single AXI valid/ready channel (AW/W/AR/R/B).
//   MODE selects which timing paths are broken between the master-side
//   (upstream) and slave-side (downstream) interfaces:
//     0 = bypass      : wires only, no state
//     1 = forward     : valid/data registered (output register)
//     2 = backward    : ready registered (skid register)
//     3 = full        : output register + skid register, no comb path
//   Every mode keeps beat order, never drops or duplicates a beat and
//   sustains one beat per cycle.
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   m_data   in   [DW] upstream payload
//   m_valid  in   upstream beat valid
//   m_ready  out  slice accepts the upstream beat
//   s_data   out  [DW] downstream payload
//   s_valid  out  downstream beat valid
//   s_ready  in   downstream accepts the beat
//   fill     out  [2] beats currently held in slice registers (0..2)
module axi_reg_slice #(
  parameter int DW   = 64,
  parameter int MODE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] m_data,
  input  logic          m_valid,
  output logic          m_ready,
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [1:0]    fill
);

  generate
    if (DW < 1) begin : g_bad_dw
      $error("axi_reg_slice: DW must be >= 1");
    end

    if (MODE == 0) begin : g_bypass
      // Pure wires; clock and reset have no role here.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n};

      assign s_data  = m_data;
      assign s_valid = m_valid;
      assign m_ready = s_ready;
      assign fill    = 2'd0;

    end else if (MODE == 1) begin : g_forward
      logic [DW-1:0] r_or;
      logic          r_ov;
      logic          w_push;

      // Register may refill in the same cycle it is drained.
      assign m_ready = ~r_ov | s_ready;
      assign w_push  = m_valid & m_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_or <= '0;
          r_ov <= 1'b0;
        end else if (w_push) begin
          r_or <= m_data;
          r_ov <= 1'b1;
        end else if (s_ready) begin
          r_ov <= 1'b0;
        end
      end

      assign s_data  = r_or;
      assign s_valid = r_ov;
      assign fill    = {1'b0, r_ov};

    end else if (MODE == 2) begin : g_backward
      logic [DW-1:0] r_sr;
      logic          r_sv;

      // Capture a beat only when it was accepted (m_ready=~SV) but the
      // downstream refused it; the skid register is never overwritten
      // while occupied because m_ready is low then.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sr <= '0;
          r_sv <= 1'b0;
        end else if (m_valid && !r_sv && !s_ready) begin
          r_sr <= m_data;
          r_sv <= 1'b1;
        end else if (r_sv && s_ready) begin
          r_sv <= 1'b0;
        end
      end

      assign m_ready = ~r_sv;
      // The upstream valid flows straight through, so it is masked while
      // reset is asserted to present an idle channel immediately.
      assign s_valid = rst_n & (m_valid | r_sv);
      assign s_data  = r_sv ? r_sr : m_data;
      assign fill    = {1'b0, r_sv};

    end else if (MODE == 3) begin : g_full
      logic [DW-1:0] r_or;
      logic          r_ov;
      logic [DW-1:0] r_sr;
      logic          r_sv;
      logic          w_acc;
      logic          w_pop;

      assign w_acc = m_valid & ~r_sv;
      assign w_pop = r_ov & s_ready;

      // SV=1 implies OV=1, so the !OV branch never sees a held skid beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_or <= '0;
          r_ov <= 1'b0;
          r_sr <= '0;
          r_sv <= 1'b0;
        end else if (!r_ov) begin
          if (w_acc) begin
            r_or <= m_data;
            r_ov <= 1'b1;
          end
        end else if (w_pop) begin
          if (r_sv) begin
            // Oldest pending beat advances; upstream is stalled this cycle.
            r_or <= r_sr;
            r_sv <= 1'b0;
          end else if (w_acc) begin
            r_or <= m_data;
          end else begin
            r_ov <= 1'b0;
          end
        end else if (w_acc) begin
          r_sr <= m_data;
          r_sv <= 1'b1;
        end
      end

      assign m_ready = ~r_sv;
      assign s_valid = r_ov;
      assign s_data  = r_or;
      assign fill    = {1'b0, r_ov} + {1'b0, r_sv};

    end else begin : g_bad_mode
      $error("axi_reg_slice: MODE must be 0..3");
    end
  endgenerate

endmodule
